// File: rtl/button_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_queue_pkg
//  Description : Shared constants for the button event queue. These are the
//                dmem address map and the code returned when the queue is
//                empty.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_event_queue_pkg;

    // Memory-mapped register addresses (dmem memAddr[11:0])
    localparam logic [11:0] c_addr_data   = 12'd6;   // lw: head code, sw: pop
    localparam logic [11:0] c_addr_status = 12'd7;   // lw: status, sw: clear overflow

    // Returned at the data address when nothing is queued
    localparam logic [31:0] c_empty_code  = 32'hFFFF_FFFF;

    // Status word layout: sticky overflow in bit 31, entry count in the low half
    function automatic logic [31:0] status_word(input logic ovf, input logic [15:0] cnt);
        return {ovf, 15'b0, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_queue_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_queue_debouncer
//  Description : One push-button input path. It has a 2-flop synchroniser, a
//                stability counter and an accepted (stable) level. It emits a
//                one-cycle press pulse on the cycle the stable level flips from
//                0 to 1.
//  Ports       : clock   - system clock
//                reset   - asynchronous, active-low
//                btn_raw - raw asynchronous button level (active-high)
//                press   - one-cycle pulse per debounced press (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_queue_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_vld1;
    logic          r_vld2;
    logic          r_stable;
    logic          r_armed;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_flip;

    assign w_differ = (r_sync2 != r_stable);
    assign w_flip   = w_differ && (r_cnt == c_cnt_last);

    // A button held through reset must not produce an event when it is
    // accepted afterwards. So a press only counts once the synchroniser has
    // refilled (r_vld2) and has shown the button released at least once.
    assign press    = w_flip && !r_stable && r_armed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_vld1   <= 1'b0;
            r_vld2   <= 1'b0;
            r_stable <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_vld1  <= 1'b1;
            r_vld2  <= r_vld1;

            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_vld2 && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_queue
//  Description : Memory-mapped push-button input stage. Each button is
//                debounced, and every debounced press is queued as its button
//                index in a small FIFO. The game loop polls the queue with lw
//                and consumes entries with sw.
//  Ports       : clock    - system clock
//                reset    - asynchronous, active-low
//                btn_raw  - raw button levels, one bit per button
//                addr     - dmem address memAddr[11:0]
//                wren     - dmem write enable
//                hit      - addr selects this block (combinational)
//                q_out    - read data for addr (combinational)
//                overflow - sticky overflow flag (debug LED)
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_queue
    import button_event_queue_pkg::*;
#(
    parameter int          NUM_BTNS        = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          DEPTH           = 8,
    parameter logic [11:0] ADDR_DATA       = c_addr_data,
    parameter logic [11:0] ADDR_STATUS     = c_addr_status
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic [11:0]         addr,
    input  logic                wren,
    output logic                hit,
    output logic [31:0]         q_out,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

    logic [NUM_BTNS-1:0] w_press;
    logic [NUM_BTNS-1:0] r_pend;
    logic [NUM_BTNS-1:0] w_clr;
    logic [IW-1:0]       w_push_idx;
    logic                w_push;

    logic [IW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_ovf;

    logic                w_sel_data;
    logic                w_sel_status;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_write;
    logic                w_ovf_set;
    logic                w_ovf_clr;

    // ------------------------------------------------------------------
    // Per-button input paths
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        button_event_queue_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn_raw[g]),
            .press   (w_press[g])
        );
    end

    // Lowest-index pending button wins the single push slot this cycle.
    // The loop runs downward, so the last match is the lowest index.
    always_comb begin
        w_push_idx = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_push_idx = IW'(i);
            end
        end
    end

    assign w_push       = |r_pend;
    assign w_clr        = w_push ? (NUM_BTNS'(1) << w_push_idx) : '0;

    assign w_sel_data   = (addr == ADDR_DATA);
    assign w_sel_status = (addr == ADDR_STATUS);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == (AW + 1)'(DEPTH));
    assign w_pop        = wren && w_sel_data && !w_empty;
    // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
    assign w_write      = w_push && (!w_full || w_pop);
    assign w_ovf_set    = w_push && w_full && !w_pop;
    assign w_ovf_clr    = wren && w_sel_status;

    // ------------------------------------------------------------------
    // Pending bits: a press on an already-pending button merges with it.
    // The bit is cleared when its push is taken, even if the push is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_press;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A set in the same cycle as a clear takes priority.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage is not reset because the count gates every read of it.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_push_idx;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (no side effects)
    // ------------------------------------------------------------------
    always_comb begin
        hit   = 1'b0;
        q_out = '0;
        if (w_sel_data) begin
            hit   = 1'b1;
            q_out = w_empty ? c_empty_code : 32'(r_mem[r_rd_ptr]);
        end else if (w_sel_status) begin
            hit   = 1'b1;
            q_out = status_word(r_ovf, 16'(r_count));
        end
    end

    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_queue
//  Description : Self-checking bench for button_event_queue. Directed press
//                and bus scenarios run first, then randomized button activity
//                with random bus traffic. Reads are checked by a scoreboard
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_queue;

    localparam int NB    = 4;
    localparam int DEB   = 16;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  btn   = '0;
    logic [11:0] addr  = '0;
    logic        wren  = 1'b0;
    logic        hit;
    logic [31:0] q_out;
    logic        overflow;

    always #5 clock = ~clock;

    button_event_queue #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DEB),
        .DEPTH           (DEPTH),
        .ADDR_DATA       (12'd6),
        .ADDR_STATUS     (12'd7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn),
        .addr     (addr),
        .wren     (wren),
        .hit      (hit),
        .q_out    (q_out),
        .overflow (overflow)
    );

    typedef struct {
        logic [31:0] q;
        logic        hit;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   lw_en  = 1'b0;

    // ------------------------------------------------------------------
    // Behavioural model. A button's accepted level changes once its raw
    // level, seen two cycles late, has disagreed with the accepted level
    // for DEB consecutive cycles. A rising acceptance is an event only if
    // the button has been seen released since reset. Events wait in a
    // pending set and move, lowest index first, one per cycle into a
    // bounded queue.
    // ------------------------------------------------------------------
    int unsigned m_q[$];
    bit          m_ovf;
    bit [NB-1:0] m_pend;
    bit          m_d1[NB];
    bit          m_d2[NB];
    bit          m_stable[NB];
    bit          m_armed[NB];
    int          m_run[NB];
    int          m_edges;

    always @(posedge clock or negedge reset) begin
        bit [NB-1:0] ev;
        bit          pop_now;
        bit          full_now;
        bit          set_now;
        bit          found;
        int          idx;
        if (!reset) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_pend  = '0;
            m_edges = 0;
            for (int b = 0; b < NB; b++) begin
                m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_stable[b] = 1'b0;
                m_armed[b] = 1'b0; m_run[b] = 0;
            end
        end else begin
            m_edges++;
            ev = '0;
            for (int b = 0; b < NB; b++) begin
                if (m_d2[b] != m_stable[b]) m_run[b]++;
                else                        m_run[b] = 0;
                if (m_run[b] == DEB) begin
                    m_stable[b] = !m_stable[b];
                    m_run[b]    = 0;
                    if (m_stable[b] && m_armed[b]) ev[b] = 1'b1;
                end
                if (m_edges >= 3 && !m_d2[b]) m_armed[b] = 1'b1;
                m_d2[b] = m_d1[b];
                m_d1[b] = btn[b];
            end
            pop_now  = wren && (addr == 12'd6) && (m_q.size() != 0);
            full_now = (m_q.size() == DEPTH);
            set_now  = 1'b0;
            if (pop_now) void'(m_q.pop_front());
            found = 1'b0;
            idx   = 0;
            for (int b = 0; b < NB; b++) begin
                if (m_pend[b] && !found) begin
                    found = 1'b1;
                    idx   = b;
                end
            end
            if (found) begin
                m_pend[idx] = 1'b0;
                if (!full_now || pop_now) m_q.push_back(idx);
                else                      set_now = 1'b1;
            end
            if (wren && addr == 12'd7) m_ovf = 1'b0;
            if (set_now)               m_ovf = 1'b1;
            m_pend = m_pend | ev;
        end
    end

    function automatic exp_t model_read(input logic [11:0] a, input string nm);
        exp_t e;
        e.name = nm;
        if (a == 12'd6) begin
            e.hit = 1'b1;
            e.q   = (m_q.size() != 0) ? 32'(m_q[0]) : 32'hFFFF_FFFF;
        end else if (a == 12'd7) begin
            e.hit = 1'b1;
            e.q   = {m_ovf, 15'b0, 16'(m_q.size())};
        end else begin
            e.hit = 1'b0;
            e.q   = '0;
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every presented read against the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (lw_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: read at addr %0d with no expectation queued", addr);
            end else begin
                mon_e = sb.pop_front();
                if (q_out !== mon_e.q || hit !== mon_e.hit) begin
                    errors++;
                    $display("FAIL %s: got q_out=%h hit=%b, expected q_out=%h hit=%b",
                             mon_e.name, q_out, hit, mon_e.q, mon_e.hit);
                end
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow_pin: got %b, expected %b", overflow, m_ovf);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic lw_exp(input logic [11:0] a, input logic [31:0] q, input logic h, input string nm);
        exp_t e;
        e.q = q; e.hit = h; e.name = nm;
        sb.push_back(e);
        addr  = a;
        wren  = 1'b0;
        lw_en = 1'b1;
        cyc(1);
        lw_en = 1'b0;
    endtask

    task automatic sw(input logic [11:0] a);
        addr = a;
        wren = 1'b1;
        cyc(1);
        wren = 1'b0;
    endtask

    task automatic press(input int b, input int hold, input int gap);
        btn[b] = 1'b1;
        cyc(hold);
        btn[b] = 1'b0;
        cyc(gap);
    endtask

    // One cycle of randomized traffic; pop_pct sets how often the data word is consumed
    task automatic rand_cycle(input int pop_pct);
        int unsigned r;
        logic [11:0] ra;
        exp_t        e;
        for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 24) == 0) btn[b] = ~btn[b];
        end
        r = $urandom_range(0, 99);
        if (r < pop_pct) begin
            addr = 12'd6; wren = 1'b1;
        end else if (r < pop_pct + 3) begin
            addr = 12'd7; wren = 1'b1;
        end else if (r < pop_pct + 50) begin
            case ($urandom_range(0, 4))
                0:       ra = 12'd6;
                1:       ra = 12'd7;
                2:       ra = 12'd5;
                3:       ra = 12'd0;
                default: ra = 12'($urandom);
            endcase
            e     = model_read(ra, "rand_read");
            sb.push_back(e);
            addr  = ra; wren = 1'b0; lw_en = 1'b1;
        end else begin
            addr = 12'($urandom); wren = $urandom_range(0, 1) == 1;
            if (addr == 12'd6 || addr == 12'd7) wren = 1'b0;
        end
        cyc(1);
        lw_en = 1'b0;
        wren  = 1'b0;
    endtask

    int codes5[8] = '{0, 1, 3, 0, 1, 3, 0, 1};
    int after5[8] = '{1, 3, 0, 1, 3, 0, 1, 2};

    initial begin
        // Reset state: reads are live while reset is held
        cyc(2);
        lw_exp(12'd6, 32'hFFFF_FFFF, 1'b1, "reset_data_empty");
        lw_exp(12'd7, 32'h0,         1'b1, "reset_status");
        lw_exp(12'd5, 32'h0,         1'b0, "reset_other_addr");
        reset = 1'b1;
        cyc(5);

        // 1: single press of button 2
        press(2, 30, 0);
        lw_exp(12'd6, 32'd2, 1'b1, "t1_head_code");
        lw_exp(12'd7, 32'd1, 1'b1, "t1_status_count1");
        sw(12'd6);
        lw_exp(12'd6, 32'hFFFF_FFFF, 1'b1, "t1_empty_after_pop");
        cyc(25);

        // 2: glitch shorter than the debounce window
        press(0, 10, 40);
        lw_exp(12'd7, 32'd0, 1'b1, "t2_glitch_no_event");

        // 3: simultaneous presses drain lowest index first
        btn = 4'b1010;
        cyc(30);
        btn = 4'b0000;
        lw_exp(12'd6, 32'd1, 1'b1, "t3_first_code");
        sw(12'd6);
        lw_exp(12'd6, 32'd3, 1'b1, "t3_second_code");
        sw(12'd6);
        lw_exp(12'd7, 32'd0, 1'b1, "t3_drained");
        cyc(25);

        // 4: nine presses into an eight-entry queue
        for (int k = 0; k < 9; k++) press(k % 4, 25, 25);
        lw_exp(12'd7, 32'h8000_0008, 1'b1, "t4_full_overflow");
        for (int k = 0; k < 8; k++) begin
            lw_exp(12'd6, 32'(k % 4), 1'b1, "t4_fifo_order");
            sw(12'd6);
        end
        lw_exp(12'd7, 32'h8000_0000, 1'b1, "t4_empty_ovf_sticky");
        sw(12'd7);
        lw_exp(12'd7, 32'd0, 1'b1, "t4_ovf_cleared");

        // 5: push lands in the same cycle as a pop on a full queue
        for (int k = 0; k < 8; k++) press(codes5[k], 25, 25);
        lw_exp(12'd7, 32'd8, 1'b1, "t5_full_before");
        btn[2] = 1'b1;
        cyc(18);
        sw(12'd6);
        lw_exp(12'd7, 32'd8, 1'b1, "t5_full_after_no_ovf");
        cyc(10);
        btn[2] = 1'b0;
        cyc(25);
        for (int k = 0; k < 8; k++) begin
            lw_exp(12'd6, 32'(after5[k]), 1'b1, "t5_order");
            sw(12'd6);
        end
        lw_exp(12'd7, 32'd0, 1'b1, "t5_drained");

        // 6: reset mid-operation with button 0 held
        press(1, 25, 25);
        press(2, 25, 25);
        btn[0] = 1'b1;
        cyc(25);
        lw_exp(12'd7, 32'd3, 1'b1, "t6_three_queued");
        reset = 1'b0;
        lw_exp(12'd6, 32'hFFFF_FFFF, 1'b1, "t6_reset_empties");
        lw_exp(12'd7, 32'd0, 1'b1, "t6_reset_status");
        reset = 1'b1;
        cyc(40);
        lw_exp(12'd7, 32'd0, 1'b1, "t6_held_no_event");
        btn[0] = 1'b0;
        cyc(25);
        lw_exp(12'd7, 32'd0, 1'b1, "t6_release_no_event");
        press(0, 25, 25);
        lw_exp(12'd6, 32'd0, 1'b1, "t6_repress_event");
        lw_exp(12'd7, 32'd1, 1'b1, "t6_repress_count");
        sw(12'd6);

        // Random traffic: a filling phase with rare pops, then a draining phase
        for (int i = 0; i < 2500; i++) rand_cycle(2);
        for (int i = 0; i < 2500; i++) rand_cycle(20);
        btn = '0;
        for (int i = 0; i < 60; i++) rand_cycle(30);

        cyc(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations never consumed, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
